// File: rtl/pipe_rr_scheduler_pkg.sv
`default_nettype none
`ifndef PIPE_RR_SCHEDULER_PKG_SV
`define PIPE_RR_SCHEDULER_PKG_SV
// ============================================================================
// Module   : pipe_rr_scheduler_pkg
// Purpose  : Shared sizing helpers for the round-robin pipeline scheduler
// Revision : 1.0 - initial release
// ============================================================================
package pipe_rr_scheduler_pkg;

  // Ceiling log2; clog2(1) is 0.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result++;
      rem = rem >> 1;
    end
    return result;
  endfunction

  // Requester ID width; never below one bit.
  function automatic int id_width(input int num_req);
    return (clog2(num_req) < 1) ? 1 : clog2(num_req);
  endfunction

  // Counter width able to hold 0..max_inflight inclusive.
  function automatic int cnt_width(input int max_inflight);
    return clog2(max_inflight + 1);
  endfunction

  localparam int DEFAULT_NUM_REQ      = 4;
  localparam int DEFAULT_DATA_WIDTH   = 16;
  localparam int DEFAULT_LATENCY      = 2;
  localparam int DEFAULT_MAX_INFLIGHT = 4;

endpackage
`endif
`default_nettype wire

// File: rtl/pipe_rr_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : pipe_rr_scheduler_if
// Purpose  : Requester, datapath and response signals of the scheduler
// Revision : 1.0 - initial release
// ============================================================================
interface pipe_rr_scheduler_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16
) ();

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          flush;
  logic                          pipe_in_valid;
  logic [DATA_WIDTH-1:0]         pipe_in_data;
  logic [DATA_WIDTH-1:0]         pipe_out_data;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0]         rsp_data;
  logic                          busy;

  // Environment side: requesters, flush source and the shared datapath
  modport master (
    output req_valid, req_data, flush, pipe_out_data,
    input  req_ready, pipe_in_valid, pipe_in_data, rsp_valid, rsp_data, busy
  );

  // Scheduler side
  modport slave (
    input  req_valid, req_data, flush, pipe_out_data,
    output req_ready, pipe_in_valid, pipe_in_data, rsp_valid, rsp_data, busy
  );

endinterface
`default_nettype wire

// File: rtl/pipe_rr_scheduler_tag_delay_line.sv
`default_nettype none
// ============================================================================
// Module   : tag_delay_line
// Purpose  : Valid+tag shift register that tracks work inside the datapath
// Revision : 1.0 - initial release
// ============================================================================
module tag_delay_line #(
  parameter int NUM_STAGES = 2,
  parameter int TAG_WIDTH  = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clear,
  input  logic                 in_valid,
  input  logic [TAG_WIDTH-1:0] in_tag,
  output logic                 out_valid,
  output logic [TAG_WIDTH-1:0] out_tag,
  output logic                 any_valid
);

  logic [NUM_STAGES-1:0] valid_q;
  logic [TAG_WIDTH-1:0]  tag_q [NUM_STAGES];

  // Valid bits shift each cycle; flush drops them all at once
  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      valid_q <= '0;
    end else begin
      valid_q[0] <= in_valid;
      for (int s = 1; s < NUM_STAGES; s++) begin
        valid_q[s] <= valid_q[s-1];
      end
    end
  end

  // Tags follow the valids; only reset clears them since a stale tag is harmless
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int s = 0; s < NUM_STAGES; s++) begin
        tag_q[s] <= '0;
      end
    end else begin
      tag_q[0] <= in_tag;
      for (int s = 1; s < NUM_STAGES; s++) begin
        tag_q[s] <= tag_q[s-1];
      end
    end
  end

  assign out_valid = valid_q[NUM_STAGES-1];
  assign out_tag   = tag_q[NUM_STAGES-1];
  assign any_valid = |valid_q;

endmodule
`default_nettype wire

// File: rtl/pipe_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : pipe_rr_scheduler
// Purpose  : Round-robin sharing of one fixed-latency datapath among
//            NUM_REQ requesters with per-requester in-flight limits
// Revision : 1.0 - initial release
// ============================================================================
module pipe_rr_scheduler #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_WIDTH   = 16,
  parameter int LATENCY      = 2,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  pipe_rr_scheduler_if.slave bus
);
  import pipe_rr_scheduler_pkg::*;

  localparam int ID_WIDTH  = id_width(NUM_REQ);
  localparam int CNT_WIDTH = cnt_width(MAX_INFLIGHT);

  logic [ID_WIDTH-1:0]   ptr;
  logic [CNT_WIDTH-1:0]  cnt [NUM_REQ];
  logic [NUM_REQ-1:0]    eligible;
  logic [NUM_REQ-1:0]    grant;
  logic [NUM_REQ-1:0]    rsp_vec;
  logic                  hs;
  logic [ID_WIDTH-1:0]   gid;
  logic [DATA_WIDTH-1:0] win_data;

  logic                  issue_valid;
  logic [DATA_WIDTH-1:0] issue_data;
  logic [ID_WIDTH-1:0]   issue_id;

  logic                  tag_last_valid;
  logic [ID_WIDTH-1:0]   tag_last_id;
  logic                  tag_any_valid;

  // Response decode; suppressed while flushing or in reset
  always_comb begin
    rsp_vec = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (tag_last_valid && reset_n && !bus.flush && (tag_last_id == ID_WIDTH'(i))) begin
        rsp_vec[i] = 1'b1;
      end
    end
  end

  // A returning response frees its slot in the same cycle
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_elig
    assign eligible[i] = bus.req_valid[i] &&
                         ((cnt[i] - CNT_WIDTH'(rsp_vec[i])) < CNT_WIDTH'(MAX_INFLIGHT));
  end

  // Round-robin search starting at ptr, wrapping around
  always_comb begin
    int idx;
    idx   = 0;
    grant = '0;
    gid   = '0;
    hs    = 1'b0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = int'(ptr) + off;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!hs && eligible[idx]) begin
        grant[idx] = 1'b1;
        gid        = ID_WIDTH'(idx);
        hs         = 1'b1;
      end
    end
    if (!reset_n || bus.flush) begin
      grant = '0;
      hs    = 1'b0;
    end
  end

  assign win_data = bus.req_data[gid*DATA_WIDTH +: DATA_WIDTH];

  // Pointer moves just past the winner; holds otherwise, including on flush
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ptr <= '0;
    end else if (hs) begin
      ptr <= (gid == ID_WIDTH'(NUM_REQ - 1)) ? '0 : gid + 1'b1;
    end
  end

  // Issue stage feeding the datapath; payload holds when idle
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      issue_valid <= 1'b0;
      issue_data  <= '0;
      issue_id    <= '0;
    end else if (hs) begin
      issue_valid <= 1'b1;
      issue_data  <= win_data;
      issue_id    <= gid;
    end else begin
      issue_valid <= 1'b0;
    end
  end

  // Outstanding-work counters; grant and response together cancel out
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!reset_n || bus.flush) begin
        cnt[i] <= '0;
      end else if (grant[i] && !rsp_vec[i]) begin
        cnt[i] <= cnt[i] + 1'b1;
      end else if (!grant[i] && rsp_vec[i]) begin
        cnt[i] <= cnt[i] - 1'b1;
      end
    end
  end

`ifndef SYNTHESIS
  // A response for a requester with nothing outstanding means the tags are corrupt
  always @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rsp_vec[i] && !grant[i]) begin
        assert (cnt[i] != '0) else $error("in-flight counter underflow on requester %0d", i);
      end
    end
  end
`endif

  tag_delay_line #(
    .NUM_STAGES (LATENCY),
    .TAG_WIDTH  (ID_WIDTH)
  ) u_tag_line (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (bus.flush),
    .in_valid  (issue_valid),
    .in_tag    (issue_id),
    .out_valid (tag_last_valid),
    .out_tag   (tag_last_id),
    .any_valid (tag_any_valid)
  );

  assign bus.req_ready     = grant;
  assign bus.pipe_in_valid = issue_valid;
  assign bus.pipe_in_data  = issue_data;
  assign bus.rsp_valid     = rsp_vec;
  assign bus.rsp_data      = bus.pipe_out_data;
  assign bus.busy          = issue_valid | tag_any_valid;

endmodule
`default_nettype wire

// File: tb/tb_pipe_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_rr_scheduler
// Purpose  : Self-checking bench for pipe_rr_scheduler against a
//            transaction-level reference model
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_rr_scheduler;

  localparam int NR   = 4;
  localparam int DW   = 16;
  localparam int LAT  = 4;
  localparam int MAXF = 2;
  localparam logic [DW-1:0] XFORM = 16'hA5A5;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  always #5 clk = ~clk;

  pipe_rr_scheduler_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

  pipe_rr_scheduler #(
    .NUM_REQ      (NR),
    .DATA_WIDTH   (DW),
    .LATENCY      (LAT),
    .MAX_INFLIGHT (MAXF)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Stand-in datapath: LAT register stages with a visible transform
  logic [DW-1:0] dl [LAT];
  always @(posedge clk) begin
    dl[0] <= bus.pipe_in_data ^ XFORM;
    for (int s = 1; s < LAT; s++) dl[s] <= dl[s-1];
  end
  assign bus.pipe_out_data = dl[LAT-1];

  // Reference model: list of accepted transactions with their issue cycle
  typedef struct {
    int            id;
    int            issued;
    int            due;
    logic [DW-1:0] data;
  } ent_t;

  ent_t q[$];
  int   ptr_m      = 0;
  int   cyc        = 0;
  int   vectors    = 0;
  int   miscompares = 0;
  bit   checks_on  = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step(input logic [NR-1:0] v, input bit fl, input bit rn);
    int            eff [NR];
    logic [NR-1:0] eg;
    logic [NR-1:0] er;
    logic [DW-1:0] erd;
    logic [DW-1:0] epd;
    bit            eb;
    bit            ep;
    int            g;
    int            idx;

    bus.req_valid = v;
    bus.req_data  = {$urandom(), $urandom()};
    bus.flush     = fl;
    reset_n       = rn;
    @(negedge clk);

    for (int i = 0; i < NR; i++) eff[i] = 0;
    er  = '0;
    erd = '0;
    epd = '0;
    eb  = 1'b0;
    ep  = 1'b0;
    foreach (q[k]) begin
      // Outstanding after any response returning this cycle
      if (q[k].due > cyc) eff[q[k].id]++;
      if (rn && !fl && q[k].due == cyc) begin
        er[q[k].id] = 1'b1;
        erd         = q[k].data ^ XFORM;
      end
      if (q[k].issued < cyc && q[k].due >= cyc) eb = 1'b1;
      if (q[k].issued == cyc - 1) begin
        ep  = 1'b1;
        epd = q[k].data;
      end
    end

    eg = '0;
    g  = -1;
    if (rn && !fl) begin
      for (int off = 0; off < NR; off++) begin
        idx = (ptr_m + off) % NR;
        if (g < 0 && v[idx] && eff[idx] < MAXF) begin
          g       = idx;
          eg[idx] = 1'b1;
        end
      end
    end

    check("req_ready", 64'(bus.req_ready), 64'(eg));
    check("rsp_valid", 64'(bus.rsp_valid), 64'(er));
    if (er != '0) check("rsp_data", 64'(bus.rsp_data), 64'(erd));
    if (checks_on) begin
      check("pipe_in_valid", 64'(bus.pipe_in_valid), 64'(ep));
      if (ep) check("pipe_in_data", 64'(bus.pipe_in_data), 64'(epd));
      check("busy", 64'(bus.busy), 64'(eb));
    end

    // Effects of the coming clock edge
    if (!rn) begin
      q.delete();
      ptr_m = 0;
    end else if (fl) begin
      q.delete();
    end else begin
      for (int k = q.size() - 1; k >= 0; k--) begin
        if (q[k].due == cyc) q.delete(k);
      end
      if (g >= 0) begin
        q.push_back('{g, cyc, cyc + 1 + LAT, bus.req_data[g*DW +: DW]});
        ptr_m = (g + 1) % NR;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
    if (!rn) checks_on = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(4'b0000, 1'b0, 1'b1);
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.flush     = 1'b0;

    // Reset held with every requester asking
    repeat (3) step(4'b1111, 1'b0, 1'b0);

    // Release, then all requesters valid: rotation 0,1,2,3,0,1,2,3
    repeat (8) step(4'b1111, 1'b0, 1'b1);
    idle(8);

    // Park pointer at 2, then only 1 and 3 request: 3,1,3,1
    step(4'b0010, 1'b0, 1'b1);
    idle(7);
    repeat (4) step(4'b1010, 1'b0, 1'b1);
    idle(8);

    // Lone requester 2 hits the in-flight limit and waits for returns
    repeat (12) step(4'b0100, 1'b0, 1'b1);
    idle(8);

    // Three issues, flush one cycle before the first response is due
    repeat (3) step(4'b1111, 1'b0, 1'b1);
    step(4'b0000, 1'b0, 1'b1);
    step(4'b1111, 1'b1, 1'b1);
    step(4'b1111, 1'b0, 1'b1);
    idle(8);

    // Reset with two requests in flight; pointer restarts at 0
    step(4'b0100, 1'b0, 1'b1);
    step(4'b1000, 1'b0, 1'b1);
    step(4'b0000, 1'b0, 1'b0);
    idle(6);
    repeat (3) step(4'b1111, 1'b0, 1'b1);
    idle(8);

    // Random traffic with occasional flush and reset
    repeat (300) begin
      step(4'($urandom_range(0, 15)), ($urandom_range(0, 15) == 0), ($urandom_range(0, 63) != 0));
    end
    idle(8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_rr_scheduler.md
# pipe_rr_scheduler

Round-robin scheduler that shares one fixed-latency pipelined datapath (a staged register or compute chain of depth `LATENCY`) between `NUM_REQ` requesters. It accepts at most one request per cycle and registers it into the datapath input. A requester-ID tag travels alongside the data so each result returns to the requester that issued it. A per-requester in-flight limit and a flush input bound and clear the outstanding work.

## Interface
- `NUM_REQ`, 4: number of requesters, at least 2.
- `DATA_WIDTH`, 16: payload width, in and out.
- `LATENCY`, 2: cycles from `PIPE_IN_*` to `PIPE_OUT_DATA`, at least 1.
- `MAX_INFLIGHT`, 4: maximum outstanding requests per requester, at least 1.
- `CLK`  in  1  clock; all logic is on the rising edge.
- `RESET_N`  in  1  synchronous, active-low reset.
- `REQ_VALID`  in  `NUM_REQ`  request valid, one bit per requester.
- `REQ_DATA`  in  `NUM_REQ*DATA_WIDTH`  request payloads; requester i uses `[i*DATA_WIDTH+:DATA_WIDTH]`.
- `REQ_READY`  out  `NUM_REQ`  one-hot grant; handshake when `REQ_VALID[i]` and `REQ_READY[i]` are both high.
- `FLUSH`  in  1  discard all in-flight work.
- `PIPE_IN_VALID`  out  1  datapath input valid (registered).
- `PIPE_IN_DATA`  out  `DATA_WIDTH`  datapath input payload (registered).
- `PIPE_OUT_DATA`  in  `DATA_WIDTH`  datapath result, `LATENCY` cycles after input.
- `RSP_VALID`  out  `NUM_REQ`  one-hot response valid.
- `RSP_DATA`  out  `DATA_WIDTH`  response payload.
- `BUSY`  out  1  high if any tag is in flight or `PIPE_IN_VALID` is high.

## Operation
- Eligibility: requester i is eligible when `REQ_VALID[i]` is high and `cnt[i] < MAX_INFLIGHT`.
- Grant:
  - Combinational and one-hot.
  - The first eligible requester is chosen, searching from `ptr` upward and wrapping modulo `NUM_REQ`.
  - No grant is given while `FLUSH` is high or `RESET_N` is low.
  - `REQ_READY` may depend on `REQ_VALID`. Requesters must not make `REQ_VALID` depend on `REQ_READY`.
- Pointer: on a handshake by requester g, `ptr` becomes (g+1) mod `NUM_REQ`. With no handshake, `ptr` holds.
- Issue register: on a handshake, the winning payload and its ID load into the issue stage. Otherwise `PIPE_IN_VALID` goes to 0 and `PIPE_IN_DATA` holds its value.
- Tag line:
  - {valid, ID} shift through `LATENCY` stages, fed from {`PIPE_IN_VALID`, issue ID}.
  - The tag at the last stage aligns with `PIPE_OUT_DATA`.
- Response:
  - `RSP_VALID` is the one-hot decode of the last-stage ID, gated by the last-stage valid.
  - `RSP_DATA` = `PIPE_OUT_DATA`, passed through combinationally.
  - Responses cannot be back-pressured.
- Counters:
  - `cnt[i]` increments on a handshake by i and decrements on `RSP_VALID[i]`.
  - Both in the same cycle leaves it unchanged.
  - Width is clog2(`MAX_INFLIGHT`+1).
  - The counter never over- or underflows; underflow is an assertion error.
- `FLUSH`:
  - Next cycle, all tag valids, the issue valid and all `cnt` are 0.
  - `RSP_VALID` is 0 during the flush cycle.
  - `ptr` is unchanged.
  - Data registers are not cleared.
- Reset (`RESET_N` low at an edge):
  - `ptr` = 0, all `cnt` = 0, issue valid = 0, tag valids = 0, `PIPE_IN_DATA` = 0.
  - Consequently `REQ_READY`, `RSP_VALID`, `PIPE_IN_VALID` and `BUSY` are all 0.
  - Reset mid-operation drops in-flight work silently; no responses are produced for it.
- Simultaneous events: `FLUSH` together with a handshake-eligible request is not a handshake, because `REQ_READY` is forced to 0.

## Timing
- Handshake at edge t → `PIPE_IN_VALID` high in cycle t+1 → `RSP_VALID` high in cycle t+1+`LATENCY`. Total latency is `LATENCY`+1.
- Throughput: one issue per cycle, sustained, for as long as any requester is eligible.
- In-flight limit:
  - A requester with `cnt` = `MAX_INFLIGHT` regains eligibility in the same cycle its response appears.
  - This holds because the decrement is seen combinationally through the compare on `cnt`, as registered, minus `RSP_VALID`.
- Single requester at `MAX_INFLIGHT` < `LATENCY`+1: issues `MAX_INFLIGHT` back-to-back, then stalls until its responses return.

## Structure
- Shared header holds the constants: `ID_WIDTH` = max(1, clog2(`NUM_REQ`)), `CNT_WIDTH`, and a clog2 function. It uses the include-guard style.
- Sub-module `tag_delay_line`:
  - Parameters `NUM_STAGES`, `TAG_WIDTH`.
  - Carries a valid-plus-tag shift register with synchronous active-low reset and a synchronous clear of the valid bits.
- The top level contains the arbiter, pointer, issue register, counters, response decode and `BUSY`.

## Test plan
- Reset: hold `RESET_N` low with all `REQ_VALID` high → `REQ_READY`=0, `RSP_VALID`=0, `PIPE_IN_VALID`=0. Release → first grant goes to requester 0.
- Fairness: `NUM_REQ`=4, all valid for 8 cycles → grants 0,1,2,3,0,1,2,3. Responses arrive with the same order and IDs at `LATENCY`+1 cycles per request. Loop back `PIPE_OUT_DATA` through a `LATENCY`-stage delay model.
- Pointer skip: only requesters 1 and 3 valid, starting from `ptr`=2 → grants 3,1,3,1.
- In-flight limit: `MAX_INFLIGHT`=2, `LATENCY`=4, requester 2 alone → two issues, 3 idle cycles, then a new grant in the cycle its first response arrives. `cnt` never exceeds 2.
- Flush: issue 3 requests, assert `FLUSH` one cycle before the first response is due → no `RSP_VALID`, all `cnt`=0, `BUSY`=0 next cycle. A new request is granted the cycle after `FLUSH` drops.
- Mid-operation reset: drive `RESET_N` low for 1 cycle with 2 requests in flight → no responses ever appear. `ptr` restarts at 0.
